// File: rtl/bldc_motion_sequencer.sv
// BLDC motion sequencer: ramps driver duty toward a commanded target, manages direction
// reversal through a disabled dwell, and retries after driver faults until lockout.
module bldc_motion_sequencer #(
  parameter int duty_width          = 10,
  parameter int ramp_step           = 4,
  parameter int ramp_interval_ticks = 10,
  parameter int stop_dwell_ticks    = 20,
  parameter int retry_holdoff_ticks = 50,
  parameter int max_retries         = 2
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_dir,
  input  logic [duty_width-1:0] cmd_duty,
  input  logic                  fault_n,
  input  logic                  hall_error,
  output logic                  drv_enable,
  output logic [1:0]            drv_direction,
  output logic [duty_width-1:0] drv_duty,
  output logic [2:0]            seq_state,
  output logic [1:0]            retry_count,
  output logic                  lockout
);

  // Direction encoding: 0 = none (stop), 1 = clockwise, 2 = counter-clockwise.
  localparam logic [1:0] DIR_NONE = 2'd0;

  localparam int CNT_MAX_A = (ramp_interval_ticks > stop_dwell_ticks) ? ramp_interval_ticks
                                                                      : stop_dwell_ticks;
  localparam int CNT_MAX   = (CNT_MAX_A > retry_holdoff_ticks) ? CNT_MAX_A : retry_holdoff_ticks;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]      RAMP_LAST  = CNT_W'(ramp_interval_ticks - 1);
  localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(stop_dwell_ticks - 1);
  localparam logic [CNT_W-1:0]      HOLD_LAST  = CNT_W'(retry_holdoff_ticks - 1);
  localparam logic [duty_width-1:0] STEP       = duty_width'(ramp_step);
  localparam logic [1:0]            MAX_RETRY  = 2'(max_retries);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RAMP       = 3'd1,
    S_HOLD       = 3'd2,
    S_STOP_DWELL = 3'd3,
    S_FAULT      = 3'd4,
    S_LOCKOUT    = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [duty_width-1:0]   duty_q, duty_d;
  logic [1:0]              dir_q, dir_d;
  logic [1:0]              tgt_dir_q, tgt_dir_d;
  logic [duty_width-1:0]   tgt_duty_q, tgt_duty_d;
  logic [1:0]              retry_q, retry_d;

  logic                    accept;
  logic                    fault_seen;
  logic [duty_width-1:0]   eff_tgt;

  // One ramp step toward the target; the last step lands exactly on it so the
  // duty can never overshoot or wrap past either end of its range.
  function automatic logic [duty_width-1:0] ramp_toward(input logic [duty_width-1:0] cur,
                                                        input logic [duty_width-1:0] tgt);
    logic [duty_width-1:0] res;
    res = cur;
    if (cur < tgt) begin
      res = ((tgt - cur) <= STEP) ? tgt : cur + STEP;
    end else if (cur > tgt) begin
      res = ((cur - tgt) <= STEP) ? tgt : cur - STEP;
    end
    return res;
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'b11) ? 2'b11 : v + 2'd1;
  endfunction

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      duty_q     <= '0;
      dir_q      <= DIR_NONE;
      tgt_dir_q  <= DIR_NONE;
      tgt_duty_q <= '0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      tgt_dir_q  <= tgt_dir_d;
      tgt_duty_q <= tgt_duty_d;
      retry_q    <= retry_d;
    end
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE) || (state_q == S_RAMP) ||
                (state_q == S_HOLD) || (state_q == S_LOCKOUT);
  end

  assign accept     = cmd_valid && cmd_ready;
  assign fault_seen = !fault_n || hall_error;
  assign eff_tgt    = (tgt_dir_q == dir_q) ? tgt_duty_q : '0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    duty_d     = duty_q;
    dir_d      = dir_q;
    tgt_dir_d  = tgt_dir_q;
    tgt_duty_d = tgt_duty_q;
    retry_d    = retry_q;

    // Lockout drops motion commands entirely; only a stop command is taken.
    if (accept && !(state_q == S_LOCKOUT && cmd_dir != DIR_NONE)) begin
      tgt_dir_d  = cmd_dir;
      tgt_duty_d = cmd_duty;
    end

    unique case (state_q)
      S_IDLE: begin
        duty_d = '0;
        dir_d  = DIR_NONE;
        if (accept && cmd_dir != DIR_NONE) begin
          dir_d   = cmd_dir;
          state_d = S_RAMP;
          cnt_d   = '0;
        end
      end
      S_RAMP: begin
        if (fault_seen) begin
          state_d = S_FAULT;
          duty_d  = '0;
          cnt_d   = '0;
          retry_d = sat_inc(retry_q);
        end else if (!accept && duty_q == eff_tgt && eff_tgt != '0) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else if (!accept && duty_q == '0 && tgt_dir_q != dir_q) begin
          state_d = S_STOP_DWELL;
          cnt_d   = '0;
        end else if (cnt_q == RAMP_LAST) begin
          cnt_d  = '0;
          duty_d = ramp_toward(duty_q, eff_tgt);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (fault_seen) begin
          state_d = S_FAULT;
          duty_d  = '0;
          cnt_d   = '0;
          retry_d = sat_inc(retry_q);
        end else if (accept) begin
          state_d = S_RAMP;
          cnt_d   = '0;
        end
      end
      S_STOP_DWELL: begin
        duty_d = '0;
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          dir_d = tgt_dir_q;
          if (tgt_dir_q == DIR_NONE) begin
            state_d = S_IDLE;
            retry_d = '0;
          end else begin
            state_d = S_RAMP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FAULT: begin
        duty_d = '0;
        // Holdoff only advances on fault-free cycles; any reassertion restarts it.
        if (fault_seen) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = (retry_q > MAX_RETRY) ? S_LOCKOUT : S_RAMP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOCKOUT: begin
        duty_d = '0;
        if (accept && cmd_dir == DIR_NONE) begin
          state_d = S_IDLE;
          dir_d   = DIR_NONE;
          retry_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        duty_d  = '0;
        dir_d   = DIR_NONE;
      end
    endcase
  end

  assign drv_enable    = (state_q == S_RAMP) || (state_q == S_HOLD);
  assign drv_direction = dir_q;
  assign drv_duty      = duty_q;
  assign seq_state     = state_q;
  assign retry_count   = retry_q;
  assign lockout       = (state_q == S_LOCKOUT);

endmodule

// File: tb/tb_bldc_motion_sequencer.sv
// Directed bench for bldc_motion_sequencer: ramp, reversal, fault retry, lockout, stop, reset.
module tb_bldc_motion_sequencer;

  logic       sys_clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_dir;
  logic [9:0] cmd_duty;
  logic       fault_n;
  logic       hall_error;
  logic       drv_enable;
  logic [1:0] drv_direction;
  logic [9:0] drv_duty;
  logic [2:0] seq_state;
  logic [1:0] retry_count;
  logic       lockout;

  int tests = 0;
  int failed = 0;

  bldc_motion_sequencer dut (
    .sys_clk       (sys_clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_dir       (cmd_dir),
    .cmd_duty      (cmd_duty),
    .fault_n       (fault_n),
    .hall_error    (hall_error),
    .drv_enable    (drv_enable),
    .drv_direction (drv_direction),
    .drv_duty      (drv_duty),
    .seq_state     (seq_state),
    .retry_count   (retry_count),
    .lockout       (lockout)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] dir, input logic [9:0] duty);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_duty  = duty;
    step(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_dir    = 2'd0;
    cmd_duty   = '0;
    fault_n    = 1'b1;
    hall_error = 1'b0;
    #1;
    chk("rst_state", 32'(seq_state), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_enable", 32'(drv_enable), 0);
    chk("rst_duty", 32'(drv_duty), 0);
    chk("rst_dir", 32'(drv_direction), 0);
    chk("rst_retry", 32'(retry_count), 0);
    chk("rst_lockout", 32'(lockout), 0);
    step(2);
    reset_n = 1'b1;
    step(1);
    chk("post_rst_idle", 32'(seq_state), 0);

    // DIR_NONE in IDLE is accepted and stays in IDLE
    send(2'd0, 10'd5);
    chk("none_idle_state", 32'(seq_state), 0);
    chk("none_idle_dir", 32'(drv_direction), 0);

    // Ramp up CW to 10
    send(2'd1, 10'd10);
    chk("ramp_state", 32'(seq_state), 1);
    chk("ramp_enable", 32'(drv_enable), 1);
    chk("ramp_dir", 32'(drv_direction), 1);
    chk("ramp_duty0", 32'(drv_duty), 0);
    step(9);
    chk("ramp_duty_pre4", 32'(drv_duty), 0);
    step(1);
    chk("ramp_duty4", 32'(drv_duty), 4);
    step(10);
    chk("ramp_duty8", 32'(drv_duty), 8);
    step(10);
    chk("ramp_duty10_clamp", 32'(drv_duty), 10);
    chk("ramp_still_ramp", 32'(seq_state), 1);
    step(1);
    chk("hold_state", 32'(seq_state), 2);

    // Reversal CW -> CCW
    send(2'd2, 10'd10);
    chk("rev_ramp_state", 32'(seq_state), 1);
    chk("rev_dir_kept", 32'(drv_direction), 1);
    step(10);
    chk("rev_duty6", 32'(drv_duty), 6);
    step(10);
    chk("rev_duty2", 32'(drv_duty), 2);
    step(10);
    chk("rev_duty0_clamp", 32'(drv_duty), 0);
    step(1);
    chk("dwell_state", 32'(seq_state), 3);
    chk("dwell_enable", 32'(drv_enable), 0);
    chk("dwell_ready", 32'(cmd_ready), 0);
    step(19);
    chk("dwell_end_state", 32'(seq_state), 3);
    chk("dwell_end_dir", 32'(drv_direction), 1);
    step(1);
    chk("rev_ramp2_state", 32'(seq_state), 1);
    chk("rev_ramp2_dir", 32'(drv_direction), 2);
    step(30);
    chk("rev_ramp2_duty", 32'(drv_duty), 10);
    step(1);
    chk("rev_hold", 32'(seq_state), 2);

    // Fault in HOLD, fault_n low 3 cycles
    fault_n = 1'b0;
    step(1);
    chk("f1_state", 32'(seq_state), 4);
    chk("f1_duty", 32'(drv_duty), 0);
    chk("f1_retry", 32'(retry_count), 1);
    chk("f1_enable", 32'(drv_enable), 0);
    step(2);
    fault_n = 1'b1;
    step(49);
    chk("f1_holdoff49", 32'(seq_state), 4);
    step(1);
    chk("f1_retry_ramp", 32'(seq_state), 1);
    chk("f1_retry_duty", 32'(drv_duty), 0);
    chk("f1_retry_dir", 32'(drv_direction), 2);
    step(31);
    chk("f1_rehold", 32'(seq_state), 2);

    // Second fault with a hall glitch during holdoff
    fault_n = 1'b0;
    step(1);
    fault_n = 1'b1;
    chk("f2_retry", 32'(retry_count), 2);
    step(20);
    hall_error = 1'b1;
    step(1);
    hall_error = 1'b0;
    chk("f2_glitch_state", 32'(seq_state), 4);
    step(49);
    chk("f2_restart49", 32'(seq_state), 4);
    step(1);
    chk("f2_retry_ramp", 32'(seq_state), 1);

    // Third fault coincident with an accepted command: fault wins
    fault_n   = 1'b0;
    cmd_valid = 1'b1;
    cmd_dir   = 2'd1;
    cmd_duty  = 10'd7;
    step(1);
    cmd_valid = 1'b0;
    fault_n   = 1'b1;
    chk("f3_fault_wins", 32'(seq_state), 4);
    chk("f3_retry", 32'(retry_count), 3);
    step(49);
    chk("f3_holdoff49", 32'(seq_state), 4);
    step(1);
    chk("lock_state", 32'(seq_state), 5);
    chk("lock_flag", 32'(lockout), 1);
    chk("lock_ready", 32'(cmd_ready), 1);
    chk("lock_enable", 32'(drv_enable), 0);
    send(2'd1, 10'd5);
    chk("lock_cw_ignored", 32'(seq_state), 5);
    send(2'd0, 10'd0);
    chk("unlock_idle", 32'(seq_state), 0);
    chk("unlock_retry", 32'(retry_count), 0);
    chk("unlock_flag", 32'(lockout), 0);
    chk("unlock_dir", 32'(drv_direction), 0);

    // Stop from HOLD
    send(2'd1, 10'd8);
    step(20);
    chk("stop_pre_duty", 32'(drv_duty), 8);
    step(1);
    chk("stop_pre_hold", 32'(seq_state), 2);
    send(2'd0, 10'd0);
    chk("stop_ramp", 32'(seq_state), 1);
    step(10);
    chk("stop_duty4", 32'(drv_duty), 4);
    step(10);
    chk("stop_duty0", 32'(drv_duty), 0);
    step(1);
    chk("stop_dwell", 32'(seq_state), 3);
    step(19);
    chk("stop_dwell_end", 32'(seq_state), 3);
    step(1);
    chk("stop_idle", 32'(seq_state), 0);
    chk("stop_idle_dir", 32'(drv_direction), 0);

    // Asynchronous reset mid-ramp at duty 8
    send(2'd1, 10'd20);
    step(20);
    chk("mid_duty8", 32'(drv_duty), 8);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_duty", 32'(drv_duty), 0);
    chk("arst_enable", 32'(drv_enable), 0);
    chk("arst_state", 32'(seq_state), 0);
    chk("arst_ready", 32'(cmd_ready), 1);
    chk("arst_dir", 32'(drv_direction), 0);
    step(1);
    reset_n = 1'b1;
    step(2);
    chk("arst_release_idle", 32'(seq_state), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/bldc_motion_sequencer.md
BLDC_MOTION_SEQUENCER -- requirements
Module: bldc_motion_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
- duty_width, 10, width of duty command/output.
- ramp_step, 4, duty increment per ramp tick.
- ramp_interval_ticks, 10, sys_clk cycles per ramp tick.
- stop_dwell_ticks, 20, cycles with driver disabled before a direction change.
- retry_holdoff_ticks, 50, fault-free cycles required before retry.
- max_retries, 2, retries allowed before lockout.
REQ-002 Ports (name, direction, width, meaning):
- sys_clk in 1 clock.
- reset_n in 1 reset.
- cmd_valid in 1 command offered.
- cmd_ready out 1 command accepted when both high.
- cmd_dir in rotation_direction_t, DIR_NONE = stop.
- cmd_duty in duty_width, target duty.
- fault_n in 1 gate driver fault, active low.
- hall_error in 1 hall sensor error.
- drv_enable out 1 driver enable.
- drv_direction out rotation_direction_t.
- drv_duty out duty_width.
- seq_state out 3 current state.
- retry_count out 2 faults since last IDLE, saturating.
- lockout out 1 high in LOCKOUT.
REQ-003 Reset reset_n, asynchronous, active-low; clock sys_clk; all state in the sys_clk domain.

Function
REQ-004 States and encoding: IDLE=0, RAMP=1, HOLD=2, STOP_DWELL=3, FAULT=4, LOCKOUT=5.
REQ-005 cmd_ready SHALL be 1 in IDLE, RAMP, HOLD and LOCKOUT, and 0 otherwise.
- An accepted command SHALL latch tgt_dir/tgt_duty.
- Its effect SHALL be visible on outputs at the next cycle at the earliest.
REQ-006 drv_enable SHALL be 1 only in RAMP and HOLD.
REQ-007 Effective target SHALL be tgt_duty if tgt_dir == drv_direction, else 0.
REQ-008 IDLE behaviour:
- drv_duty=0 and drv_direction=DIR_NONE.
- An accepted non-NONE command SHALL set drv_direction=cmd_dir and enter RAMP.
- A DIR_NONE command SHALL be accepted and leave the block in IDLE.
REQ-009 RAMP behaviour:
- Tick counter restarts on entering RAMP.
- Every ramp_interval_ticks cycles, drv_duty SHALL move toward the effective target by ramp_step.
- The final step SHALL clamp exactly to the target: no overshoot, no wrap below 0 or above 2^duty_width-1.
REQ-010 RAMP exits:
- drv_duty == effective target != 0 SHALL enter HOLD.
- drv_duty == 0 with tgt_dir != drv_direction SHALL enter STOP_DWELL.
REQ-011 HOLD behaviour: any accepted command SHALL return to RAMP on the next cycle; the tick counter restarts.
REQ-012 STOP_DWELL behaviour:
- Hold drv_duty=0 and drv_enable=0 for stop_dwell_ticks cycles.
- Then set drv_direction=tgt_dir.
- Enter IDLE if tgt_dir==DIR_NONE, else RAMP.
REQ-013 Fault detection: fault_n==0 or hall_error==1 while in RAMP or HOLD SHALL, on the next cycle:
- enter FAULT;
- force drv_duty=0;
- increment retry_count.
Faults in other states SHALL be ignored.
REQ-014 FAULT behaviour:
- Holdoff counter SHALL count cycles with fault_n==1 and hall_error==0, and restart on any fault reassertion.
- At retry_holdoff_ticks: if retry_count > max_retries, enter LOCKOUT; else enter RAMP from duty 0 toward the latched target.
REQ-015 LOCKOUT behaviour:
- Accepted non-NONE commands SHALL be dropped.
- An accepted DIR_NONE command SHALL enter IDLE.
REQ-016 retry_count SHALL clear on entering IDLE.
REQ-017 Simultaneous command acceptance and fault in the same cycle: the command SHALL be latched and the fault transition SHALL win.
REQ-018 seq_state SHALL equal the registered state.

Reset
REQ-019 On reset_n low, outputs SHALL immediately take these values, including mid-ramp or mid-dwell: state=IDLE, drv_enable=0, drv_duty=0, drv_direction=DIR_NONE, tgt_dir=DIR_NONE, tgt_duty=0, counters=0, retry_count=0, lockout=0, cmd_ready=1.
REQ-020 The first transition after release SHALL occur no earlier than the first sys_clk edge with reset_n high.

Verification (default parameters)
REQ-021 Ramp up: IDLE, cmd DIR_CW duty 10 ->
- next cycle drv_enable=1, drv_direction=DIR_CW, duty 0;
- duty 4, 8, 10 at +10, +20, +30 cycles;
- then HOLD.
REQ-022 Reversal: HOLD CW/10, cmd DIR_CCW/10 ->
- duty 6, 2, 0 at 10-cycle ticks;
- STOP_DWELL 20 cycles with drv_enable=0;
- drv_direction=DIR_CCW, RAMP up to 10.
REQ-023 Fault retry: HOLD, fault_n low 3 cycles ->
- next cycle FAULT, duty 0, retry_count=1;
- RAMP exactly 50 cycles after fault_n returns high;
- a glitch during holdoff restarts the count.
REQ-024 Lockout: 3 faults without returning to IDLE ->
- LOCKOUT, lockout=1;
- cmd DIR_CW accepted and ignored;
- cmd DIR_NONE -> IDLE, retry_count=0.
REQ-025 Stop: HOLD, cmd DIR_NONE -> ramp to 0, 20-cycle dwell, IDLE with drv_direction=DIR_NONE.
REQ-026 Reset mid-RAMP at duty 8 -> same cycle drv_duty=0, drv_enable=0, seq_state=0.
